mdu_sequencer: RTL

Multi-cycle multiply/divide sequencer for the five-stage pipeline. It sits beside the ALU in the Execute stage and owns the HI/LO architectural registers. It times each mult/multu/div/divu with a busy counter and feeds a stall request to the hazard/forwarding unit, so that a Decode-stage MDU instruction waits until the unit is free.

---
 rtl/mdu_sequencer_pkg.sv | 21 ++
 rtl/mdu_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared op codes and state encoding for the multiply/divide sequencer.
// The Controller decodes md_op using the same op codes.
package mdu_sequencer_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        MDS_IDLE = 1'b0,
        MDS_RUN  = 1'b1
    } mds_state_t;

    function automatic logic [31:0] absVal(input logic [31:0] value, input logic isSigned);
        return (isSigned && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. The result is computed
// at the start edge and held in pending registers until the latency counter expires.
import mdu_sequencer_pkg::*;

module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    mds_state_t    r_state;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pendingHi;
    logic [31:0]   r_pendingLo;

    logic          w_isMult;
    logic          w_isDiv;
    logic          w_signedOp;
    logic          w_divByZero;
    logic [31:0]   w_absA;
    logic [31:0]   w_absB;
    logic [31:0]   w_uQuot;
    logic [31:0]   w_uRem;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;
    logic [63:0]   w_product;
    logic [31:0]   w_resHi;
    logic [31:0]   w_resLo;

    assign w_isMult    = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_isDiv     = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign w_signedOp  = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign w_divByZero = (src_b == 32'd0);

    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    assign w_absA = absVal(src_a, w_signedOp);
    assign w_absB = absVal(src_b, w_signedOp);

    always_comb begin
        w_product = '0;
        w_uQuot   = '0;
        w_uRem    = '0;
        w_quot    = '0;
        w_rem     = '0;
        w_resHi   = r_hi;
        w_resLo   = r_lo;
        if (w_signedOp) begin
            w_product = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        end else begin
            w_product = {32'd0, src_a} * {32'd0, src_b};
        end
        if (!w_divByZero) begin
            w_uQuot = w_absA / w_absB;
            w_uRem  = w_absA % w_absB;
        end
        w_quot = (w_signedOp && (src_a[31] ^ src_b[31])) ? -w_uQuot : w_uQuot;
        w_rem  = (w_signedOp && src_a[31]) ? -w_uRem : w_uRem;
        if (w_isMult) begin
            w_resHi = w_product[63:32];
            w_resLo = w_product[31:0];
        end else if (!w_divByZero) begin
            w_resHi = w_rem;
            w_resLo = w_quot;
        end
    end

    // A divide by zero latches the current HI/LO as its pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MDS_IDLE;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pendingHi <= '0;
            r_pendingLo <= '0;
        end else begin
            case (r_state)
                MDS_IDLE: begin
                    if (start) begin
                        if (w_isMult || w_isDiv) begin
                            r_pendingHi <= w_resHi;
                            r_pendingLo <= w_resLo;
                            r_count     <= w_isMult ? MULT_N : DIV_N;
                            r_busy      <= 1'b1;
                            r_state     <= MDS_RUN;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= src_a;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                MDS_RUN: begin
                    if (r_count == CW'(1)) begin
                        r_hi    <= r_pendingHi;
                        r_lo    <= r_pendingLo;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= MDS_IDLE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= MDS_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_stall = d_uses_md & (start | r_busy);

endmodule
